// File: rtl/alert_pkg.sv
// Shared definitions for the alert dispatcher: message codes, pending-bit
// indices, FSM state encoding and the fixed-priority helpers.
package alert_pkg;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_FALL = 3'd1;
    localparam logic [2:0] CODE_BPM  = 3'd2;
    localparam logic [2:0] CODE_TEMP = 3'd3;
    localparam logic [2:0] CODE_MED  = 3'd4;

    localparam int PEND_FALL = 0;
    localparam int PEND_BPM  = 1;
    localparam int PEND_TEMP = 2;
    localparam int PEND_MED  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        ESCALATE = 2'd3
    } state_e;

    // Fixed priority FALL > BPM > TEMP > MED.
    function automatic logic [2:0] prio_code(input logic [3:0] pend);
        if (pend[PEND_FALL])      return CODE_FALL;
        else if (pend[PEND_BPM])  return CODE_BPM;
        else if (pend[PEND_TEMP]) return CODE_TEMP;
        else if (pend[PEND_MED])  return CODE_MED;
        else                      return CODE_NONE;
    endfunction

    // One-hot pending mask for a message code.
    function automatic logic [3:0] code_mask(input logic [2:0] code);
        case (code)
            CODE_FALL: return 4'b0001;
            CODE_BPM:  return 4'b0010;
            CODE_TEMP: return 4'b0100;
            CODE_MED:  return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset; previous sample cleared to 0
//   level - input levels
//   rise  - single-cycle pulse where level is high and was low last cycle
module rise_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;

    // prev_q resets to 0, so a level already high at reset release
    // produces an edge on the first clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= '0;
        else       prev_q <= level;
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/alert_dispatcher.sv
// Alert dispatcher: latches alarm edges as pending, serves them one at a
// time in fixed priority over a valid/ready link, beeps until acknowledged
// and escalates unacknowledged critical alarms.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   bpm_state, temp_state,
//   fall_state,
//   medicine_reminder          - alarm levels from the monitor
//   ack                        - caregiver acknowledge
//   msg_ready                  - downstream ready
//   msg_valid, msg_code        - coded message offer
//   buzzer, escalate           - local annunciation
//   pending                    - sticky flags {MED,TEMP,BPM,FALL}
//   alert_active               - FSM not in IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing being served; picks highest-priority pending alarm
// SEND     | message offered, held until msg_ready
// WAIT_ACK | message delivered, buzzer beeping, waiting for ack
// ESCALATE | critical alarm timed out; escalate high, buzzer steady
module alert_dispatcher #(
    parameter int ESC_CYCLES  = 200,
    parameter int BEEP_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bpm_state,
    input  logic       temp_state,
    input  logic       fall_state,
    input  logic       medicine_reminder,
    input  logic       ack,
    input  logic       msg_ready,
    output logic       msg_valid,
    output logic [2:0] msg_code,
    output logic       buzzer,
    output logic       escalate,
    output logic [3:0] pending,
    output logic       alert_active
);
    import alert_pkg::*;

    localparam int WW = $clog2(ESC_CYCLES);
    localparam int BW = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(ESC_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_PERIOD - 1);

    logic [3:0]    level;
    logic [3:0]    rise;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    clr_mask;
    state_e        state_q, state_d;
    logic [2:0]    cur_code_q, cur_code_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          buzz_q, buzz_d;
    logic          active_q;

    assign level = {medicine_reminder, temp_state, bpm_state, fall_state};

    rise_detect #(.WIDTH(4)) u_rise (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .rise  (rise)
    );

    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        wait_d     = wait_q;
        beep_d     = beep_q;
        buzz_d     = buzz_q;
        clr_mask   = '0;

        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    cur_code_d = prio_code(pending_q);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (msg_ready) begin
                    state_d = WAIT_ACK;
                    buzz_d  = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (beep_q == BEEP_LAST) begin
                    beep_d = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    beep_d = beep_q + BW'(1);
                end

                if (ack) begin
                    clr_mask = code_mask(cur_code_q);
                    state_d  = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    // Reminders are dismissed quietly; real alarms escalate.
                    if (cur_code_q == CODE_MED) begin
                        clr_mask = code_mask(cur_code_q);
                        state_d  = IDLE;
                    end else begin
                        state_d = ESCALATE;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ESCALATE: begin
                if (ack) begin
                    clr_mask = code_mask(cur_code_q);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counters restart on every state entry.
        if (state_d != state_q) begin
            wait_d = '0;
            beep_d = '0;
        end
    end

    // A new edge on a bit being cleared wins, so the alarm is served again.
    assign pending_d = (pending_q & ~clr_mask) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_code_q <= CODE_NONE;
            pending_q  <= '0;
            wait_q     <= '0;
            beep_q     <= '0;
            buzz_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_code_q <= cur_code_d;
            pending_q  <= pending_d;
            wait_q     <= wait_d;
            beep_q     <= beep_d;
            buzz_q     <= buzz_d;
            active_q   <= (state_d != IDLE);
        end
    end

    assign msg_valid    = (state_q == SEND);
    assign msg_code     = msg_valid ? cur_code_q : CODE_NONE;
    assign buzzer       = ((state_q == WAIT_ACK) && buzz_q) || (state_q == ESCALATE);
    assign escalate     = (state_q == ESCALATE);
    assign pending      = pending_q;
    assign alert_active = active_q;

endmodule

// File: tb/tb_alert_dispatcher.sv
module tb_alert_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       bpm_state, temp_state, fall_state, medicine_reminder;
    logic       ack, msg_ready;
    logic       msg_valid;
    logic [2:0] msg_code;
    logic       buzzer, escalate;
    logic [3:0] pending;
    logic       alert_active;

    int         checks = 0;
    int         failures = 0;
    int         xfer_cnt = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_code;

    alert_dispatcher #(.ESC_CYCLES(200), .BEEP_PERIOD(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .bpm_state         (bpm_state),
        .temp_state        (temp_state),
        .fall_state        (fall_state),
        .medicine_reminder (medicine_reminder),
        .ack               (ack),
        .msg_ready         (msg_ready),
        .msg_valid         (msg_valid),
        .msg_code          (msg_code),
        .buzzer            (buzzer),
        .escalate          (escalate),
        .pending           (pending),
        .alert_active      (alert_active)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every accepted message is popped and compared.
    always @(negedge clk) begin
        if (!reset && msg_valid && msg_ready) begin
            xfer_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL msg_unexpected: got code %0d, expected no message", msg_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (msg_code !== exp_code) begin
                    failures++;
                    $display("FAIL msg_code: got %0d, expected %0d", msg_code, exp_code);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the transfer edge.
    task automatic wait_xfer(input string name);
        int start;
        bit seen;
        start = xfer_cnt;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (xfer_cnt != start) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_xfer_timeout: got no transfer, expected one within 50 cycles", name);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fall_state = 1'b1;
        bpm_state = 1'b0;
        temp_state = 1'b0;
        medicine_reminder = 1'b0;
        ack = 1'b0;
        msg_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({msg_valid, msg_code, buzzer, escalate, pending, alert_active} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b, expected 0", {msg_valid, msg_code, buzzer, escalate, pending, alert_active});
        end
        reset = 1'b0;
        exp_q.push_back(3'd1);
        tick();
        checks++;
        if (pending !== 4'b0001 || msg_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_edge1: got pending=%b valid=%b, expected 0001/0", pending, msg_valid);
        end
        tick();
        checks++;
        if (msg_valid !== 1'b1 || msg_code !== 3'd1) begin
            failures++;
            $display("FAIL reset_edge2: got valid=%b code=%0d, expected 1/1", msg_valid, msg_code);
        end
        msg_ready = 1'b1;
        tick();
        checks++;
        if (buzzer !== 1'b1 || msg_valid !== 1'b0 || alert_active !== 1'b1) begin
            failures++;
            $display("FAIL reset_wait_entry: got buzz=%b valid=%b active=%b, expected 1/0/1", buzzer, msg_valid, alert_active);
        end
        pulse_ack();
        checks++;
        if (pending !== 4'b0000 || alert_active !== 1'b0 || buzzer !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: got pending=%b active=%b buzz=%b, expected 0000/0/0", pending, alert_active, buzzer);
        end
        fall_state = 1'b0;
        msg_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_two_alarms();
        temp_state = 1'b1;
        medicine_reminder = 1'b1;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        msg_ready = 1'b1;
        wait_xfer("temp");
        repeat (4) tick();
        pulse_ack();
        checks++;
        if (pending !== 4'b1000 || alert_active !== 1'b0) begin
            failures++;
            $display("FAIL two_after_temp: got pending=%b active=%b, expected 1000/0", pending, alert_active);
        end
        wait_xfer("med");
        repeat (4) tick();
        pulse_ack();
        checks++;
        if (pending !== 4'b0000) begin
            failures++;
            $display("FAIL two_after_med: got pending=%b, expected 0000", pending);
        end
        temp_state = 1'b0;
        medicine_reminder = 1'b0;
        msg_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        bpm_state = 1'b1;
        exp_q.push_back(3'd2);
        msg_ready = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (msg_valid !== 1'b1 || msg_code !== 3'd2 || buzzer !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b code=%0d buzz=%b, expected 1/2/0", k, msg_valid, msg_code, buzzer);
            end
            tick();
        end
        msg_ready = 1'b1;
        wait_xfer("bpm");
        checks++;
        if (buzzer !== 1'b1 || msg_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_wait_entry: got buzz=%b valid=%b, expected 1/0", buzzer, msg_valid);
        end
        pulse_ack();
        bpm_state = 1'b0;
        msg_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_escalate();
        logic exp_buzz;
        fall_state = 1'b1;
        exp_q.push_back(3'd1);
        msg_ready = 1'b1;
        wait_xfer("fall");
        msg_ready = 1'b0;
        for (int k = 0; k < 200; k++) begin
            exp_buzz = ((k / 8) % 2) == 0;
            checks++;
            if (buzzer !== exp_buzz || escalate !== 1'b0) begin
                failures++;
                $display("FAIL esc_beep[%0d]: got buzz=%b esc=%b, expected %b/0", k, buzzer, escalate, exp_buzz);
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (escalate !== 1'b1 || buzzer !== 1'b1) begin
                failures++;
                $display("FAIL esc_hold[%0d]: got esc=%b buzz=%b, expected 1/1", k, escalate, buzzer);
            end
            tick();
        end
        pulse_ack();
        checks++;
        if (pending[0] !== 1'b0 || escalate !== 1'b0 || alert_active !== 1'b0) begin
            failures++;
            $display("FAIL esc_ack: got pend0=%b esc=%b active=%b, expected 0/0/0", pending[0], escalate, alert_active);
        end
        fall_state = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_med_dismiss();
        medicine_reminder = 1'b1;
        exp_q.push_back(3'd4);
        msg_ready = 1'b1;
        wait_xfer("med1");
        msg_ready = 1'b0;
        for (int k = 0; k < 200; k++) begin
            checks++;
            if (escalate !== 1'b0 || alert_active !== 1'b1 || pending[3] !== 1'b1) begin
                failures++;
                $display("FAIL med_wait[%0d]: got esc=%b active=%b pend3=%b, expected 0/1/1", k, escalate, alert_active, pending[3]);
            end
            tick();
        end
        checks++;
        if (alert_active !== 1'b0 || pending !== 4'b0000 || escalate !== 1'b0) begin
            failures++;
            $display("FAIL med_dismiss: got active=%b pending=%b esc=%b, expected 0/0000/0", alert_active, pending, escalate);
        end
        medicine_reminder = 1'b0;
        tick();
        medicine_reminder = 1'b1;
        exp_q.push_back(3'd4);
        msg_ready = 1'b1;
        wait_xfer("med2");
        msg_ready = 1'b0;
        medicine_reminder = 1'b0;
        tick();
        medicine_reminder = 1'b1;
        exp_q.push_back(3'd4);
        pulse_ack();
        checks++;
        if (pending[3] !== 1'b1 || alert_active !== 1'b0) begin
            failures++;
            $display("FAIL med_set_wins: got pend3=%b active=%b, expected 1/0", pending[3], alert_active);
        end
        msg_ready = 1'b1;
        wait_xfer("med3");
        pulse_ack();
        checks++;
        if (pending !== 4'b0000) begin
            failures++;
            $display("FAIL med_final: got pending=%b, expected 0000", pending);
        end
        medicine_reminder = 1'b0;
        msg_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        fall_state = 1'b1;
        exp_q.push_back(3'd1);
        msg_ready = 1'b1;
        wait_xfer("rst");
        msg_ready = 1'b0;
        repeat (200) tick();
        checks++;
        if (escalate !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_escalate: got esc=%b, expected 1", escalate);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({msg_valid, msg_code, buzzer, escalate, pending, alert_active} !== 11'd0) begin
            failures++;
            $display("FAIL rst_async: got %b, expected 0", {msg_valid, msg_code, buzzer, escalate, pending, alert_active});
        end
        fall_state = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({msg_valid, buzzer, escalate, pending, alert_active} !== 8'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_after: got outs=%b queued=%0d, expected 0/0", {msg_valid, buzzer, escalate, pending, alert_active}, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_alarms();
        test_backpressure();
        test_escalate();
        test_med_dismiss();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alert_dispatcher.md
# alert_dispatcher

- Sits directly downstream of the elderly-care monitor top level.
- Consumes its level alarms (`bpm_state`, `temp_state`, `fall_state`, `medicine_reminder`) and latches each new alarm as pending.
- Serves pending alarms one at a time in fixed priority. Each served alarm goes out as a coded message over a valid/ready link to the caregiver transmitter.
- Drives a local buzzer until the caregiver acknowledges, and escalates unacknowledged critical alarms after a timeout.

## Interface

Parameters:
- `ESC_CYCLES`, default 200: cycles in WAIT_ACK before escalation or medicine auto-dismiss; must be ≥2.
- `BEEP_PERIOD`, default 8: buzzer half-period in cycles during WAIT_ACK; must be ≥1.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `bpm_state` input 1: abnormal-BPM level.
- `temp_state` input 1: critical-temperature level.
- `fall_state` input 1: fall-detected level.
- `medicine_reminder` input 1: reminder level.
- `ack` input 1: caregiver acknowledge, single-cycle pulse (longer pulses act as one per cycle sampled).
- `msg_ready` input 1: downstream ready.
- `msg_valid` output 1: message offered; reset value 0.
- `msg_code` output 3: 0 none, 1 FALL, 2 BPM, 3 TEMP, 4 MED; reset value 0.
- `buzzer` output 1: reset value 0.
- `escalate` output 1: reset value 0.
- `pending` output 4: sticky alarm flags {MED,TEMP,BPM,FALL}; reset value 0.
- `alert_active` output 1: high in any state other than IDLE; reset value 0.

## Operation

- **Edge capture**
  - Each input has a previous-sample register, reset to 0. An input already high at reset release therefore raises an edge on the first clock.
  - A rising edge sets the corresponding `pending` bit.
  - Levels that stay high raise nothing further.
- **Priority:** FALL > BPM > TEMP > MED.
- **IDLE**
  - `msg_valid` = 0, `buzzer` = 0, `escalate` = 0.
  - If `pending` ≠ 0: latch the highest-priority code into `cur_code` and go to SEND.
- **SEND**
  - `msg_valid` = 1; `msg_code` = `cur_code`, held stable until transfer.
  - On `msg_valid` & `msg_ready`: go to WAIT_ACK and clear the wait counter and beep counter.
  - `ack` is ignored in SEND.
  - Higher-priority edges arriving in SEND do not preempt the current message.
- **WAIT_ACK**
  - `buzzer` starts at 1 on entry and toggles every `BEEP_PERIOD` cycles.
  - `ack`: clear `pending[cur_code]`, then go to IDLE.
  - Wait counter reaching `ESC_CYCLES`−1 without `ack`:
    - MED: clear its pending bit and go to IDLE (auto-dismiss, no escalation).
    - Otherwise: go to ESCALATE.
- **ESCALATE**
  - `escalate` = 1; `buzzer` held steady at 1.
  - On `ack`: clear `pending[cur_code]` and go to IDLE.
- **Simultaneous events**
  - A rising edge on the bit being cleared in the same cycle: set wins, so the alarm is served again.
  - Other bits are set independently.
- **Reset mid-operation:** returns to IDLE immediately with all outputs at reset values, and any in-flight message is dropped.
- **Width rules**
  - Wait counter is $clog2(`ESC_CYCLES`) bits.
  - Beep counter is $clog2(`BEEP_PERIOD`) bits, minimum 1.
  - No counter wraps during normal operation; both are cleared on every state entry.

## Timing

- Input rises before edge E0 → `pending` bit set after E0.
- The FSM samples `pending` in IDLE at E1 and enters SEND. `msg_valid` is high in the cycle after E1, a latency of 2 cycles from input rise.
- Transfer at edge Et → WAIT_ACK; `buzzer` = 1 from the cycle after Et.
- `ack` sampled at edge Ea → IDLE; outputs drop in the cycle after Ea.
- The next pending alarm can be offered no earlier than 2 cycles after Ea.
- ESCALATE is entered exactly `ESC_CYCLES` cycles after Et when no `ack` arrives.
- `alert_active` is registered from state and is coincident with the state change.

## Structure

- **Package `alert_pkg`:**
  - Code constants CODE_NONE/FALL/BPM/TEMP/MED.
  - FSM state enum IDLE/SEND/WAIT_ACK/ESCALATE.
  - Pending bit indices.
- **Sub-module `rise_detect`**, parameterised width:
  - Holds the previous-sample register.
  - Outputs a per-bit rising-edge pulse.
  - Instantiated once with width 4.
- Everything else lives in the top: pending register, priority encoder, FSM, counters.

## Test plan

- Reset release with `fall_state`=1 → `pending`=4'b0001 after edge 1; `msg_valid`=1, `msg_code`=1 after edge 2.
- `temp_state` and `medicine_reminder` rise together, `msg_ready`=1, `ack` 5 cycles after each transfer → codes 3 then 4 delivered in order, `pending` returns to 0.
- `bpm_state` rises, `msg_ready` held 0 for 10 cycles → `msg_valid` and `msg_code`=2 stable all 10 cycles; WAIT_ACK entered only after `msg_ready`.
- FALL served, no `ack`, `ESC_CYCLES`=200 → `buzzer` toggles every 8 cycles, `escalate`=1 exactly 200 cycles after transfer; `ack` → IDLE, `pending`[0] cleared.
- MED served, no `ack` → auto-dismiss after 200 cycles with `escalate` staying 0; a new `medicine_reminder` edge coincident with `ack` → `pending`[3] remains 1 and the alarm is re-sent.
- Assert `reset` during ESCALATE → all outputs 0 and `pending`=0 asynchronously.
